// File: rtl/dogx_cfg_loader_if.sv
// Host handshake and programmer pin bundle for the DOGX config loader.
// slave = loader side, master = host/driver side.
interface dogx_cfg_loader_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  start;
  logic [DATA_WIDTH-1:0] cfg_word;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic                  CS;
  logic                  SCLK;
  logic                  SDI;

  modport master (
    output start,
    output cfg_word,
    output abort,
    input  busy,
    input  done,
    input  aborted,
    input  CS,
    input  SCLK,
    input  SDI
  );

  modport slave (
    input  start,
    input  cfg_word,
    input  abort,
    output busy,
    output done,
    output aborted,
    output CS,
    output SCLK,
    output SDI
  );
endinterface

// File: rtl/dogx_cfg_loader.sv
// DOGX serial configuration master: MSB-first frame with CS lead/lag/idle.
// All pins are registered; SCLK is a data output, never a clock.
module dogx_cfg_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int CLK_DIV    = 8,
  parameter int CS_LEAD    = 2,
  parameter int CS_LAG     = 2,
  parameter int CS_IDLE    = 4
) (
  input  logic              clk,
  input  logic              reset,
  dogx_cfg_loader_if.slave  bus
);

  localparam int BW   = $clog2(DATA_WIDTH + 1);
  localparam int M1   = (CLK_DIV > CS_LEAD) ? CLK_DIV : CS_LEAD;
  localparam int M2   = (CS_LAG > CS_IDLE) ? CS_LAG : CS_IDLE;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DIV_L  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LEAD_L = CW'(CS_LEAD - 1);
  localparam logic [CW-1:0] LAG_L  = CW'(CS_LAG - 1);
  localparam logic [CW-1:0] IDLE_L = CW'(CS_IDLE - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_LAG,
    S_GAP
  } state_t;

  state_t                r_state;
  state_t                w_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [BW-1:0]         r_bit;
  logic [BW-1:0]         w_bit;
  logic [CW-1:0]         r_cyc;
  logic [CW-1:0]         w_cyc;
  logic                  r_abt;
  logic                  w_abt;
  logic                  r_cs;
  logic                  w_cs;
  logic                  r_sclk;
  logic                  w_sclk;
  logic                  r_sdi;
  logic                  w_sdi;
  logic                  r_busy;
  logic                  w_busy;
  logic                  r_done;
  logic                  w_done;
  logic                  r_abd;
  logic                  w_abd;

  logic [CW-1:0]         w_lim;
  logic                  w_tc;
  logic                  w_last;
  logic                  w_kill;

  always_comb begin
    w_lim = '0;
    unique case (r_state)
      S_LEAD:  w_lim = LEAD_L;
      S_SHIFT: w_lim = DIV_L;
      S_LAG:   w_lim = LAG_L;
      S_GAP:   w_lim = IDLE_L;
      default: w_lim = '0;
    endcase
  end

  assign w_tc   = (r_cyc == w_lim);
  assign w_last = (r_bit == LAST_B);
  assign w_kill = bus.abort &&
                  ((r_state == S_LEAD) ||
                   (r_state == S_SHIFT) ||
                   (r_state == S_LAG));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_cyc   <= '0;
      r_abt   <= 1'b0;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdi   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abd   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_bit   <= w_bit;
      r_cyc   <= w_cyc;
      r_abt   <= w_abt;
      r_cs    <= w_cs;
      r_sclk  <= w_sclk;
      r_sdi   <= w_sdi;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_abd   <= w_abd;
    end
  end

  always_comb begin
    w_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state = S_LEAD;
      end
      S_LEAD: begin
        if (w_kill)    w_state = S_GAP;
        else if (w_tc) w_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_kill)
          w_state = S_GAP;
        else if (w_tc && r_sclk && w_last)
          w_state = S_LAG;
      end
      S_LAG: begin
        if (w_kill || w_tc) w_state = S_GAP;
      end
      S_GAP: begin
        if (w_tc) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_shift = r_shift;
    w_bit   = r_bit;
    w_cyc   = r_cyc + CW'(1);
    w_abt   = r_abt;
    w_cs    = r_cs;
    w_sclk  = r_sclk;
    w_sdi   = r_sdi;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_abd   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cyc = '0;
        if (bus.start) begin
          w_shift = bus.cfg_word;
          w_bit   = '0;
          w_abt   = 1'b0;
          w_cs    = 1'b0;
          w_sdi   = bus.cfg_word[DATA_WIDTH-1];
          w_busy  = 1'b1;
        end
      end
      S_LEAD: begin
        if (w_tc) w_cyc = '0;
      end
      S_SHIFT: begin
        if (w_tc) begin
          w_cyc  = '0;
          w_sclk = ~r_sclk;
          // next bit goes out on the falling edge; last bit is held into LAG
          if (r_sclk) begin
            w_bit = r_bit + BW'(1);
            if (!w_last) begin
              w_shift = r_shift << 1;
              w_sdi   = r_shift[DATA_WIDTH-2];
            end
          end
        end
      end
      S_LAG: begin
        if (w_tc) begin
          w_cyc = '0;
          w_cs  = 1'b1;
          w_sdi = 1'b0;
        end
      end
      S_GAP: begin
        if (w_tc) begin
          w_cyc  = '0;
          w_busy = 1'b0;
          w_done = 1'b1;
          w_abd  = r_abt;
        end
      end
      default: w_cyc = '0;
    endcase
    if (w_kill) begin
      w_cyc  = '0;
      w_cs   = 1'b1;
      w_sclk = 1'b0;
      w_sdi  = 1'b0;
      w_abt  = 1'b1;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.aborted = r_abd;
  assign bus.CS      = r_cs;
  assign bus.SCLK    = r_sclk;
  assign bus.SDI     = r_sdi;

endmodule

// File: tb/tb_dogx_cfg_loader.sv
// Directed bench for dogx_cfg_loader: nominal, handshake, abort,
// mid-frame reset and the all-ones-timing corner on a second instance.
module tb_dogx_cfg_loader;

  logic clk;
  logic rst_n;

  dogx_cfg_loader_if #(.DATA_WIDTH(64)) ifa ();
  dogx_cfg_loader_if #(.DATA_WIDTH(64)) ifb ();

  dogx_cfg_loader #(
    .DATA_WIDTH(64), .CLK_DIV(2),
    .CS_LEAD(4), .CS_LAG(4), .CS_IDLE(4)
  ) u_a (
    .clk(clk), .reset(rst_n), .bus(ifa)
  );

  dogx_cfg_loader #(
    .DATA_WIDTH(64), .CLK_DIV(1),
    .CS_LEAD(1), .CS_LAG(1), .CS_IDLE(1)
  ) u_b (
    .clk(clk), .reset(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // pin monitors, sampled on the falling clk edge
  int          a_rises = 0, a_cslow = 0, a_high = 0;
  int          b_rises = 0, b_cslow = 0, b_high = 0;
  logic [63:0] a_cap = '0, b_cap = '0;
  logic        a_prev = 1'b0, b_prev = 1'b0;

  always @(negedge clk) begin
    if (ifa.SCLK && !a_prev) begin
      a_rises <= a_rises + 1;
      a_cap   <= {a_cap[62:0], ifa.SDI};
    end
    a_prev <= ifa.SCLK;
    if (!ifa.CS) a_cslow <= a_cslow + 1;
    if (ifa.SCLK) a_high <= a_high + 1;
  end

  always @(negedge clk) begin
    if (ifb.SCLK && !b_prev) begin
      b_rises <= b_rises + 1;
      b_cap   <= {b_cap[62:0], ifb.SDI};
    end
    b_prev <= ifb.SCLK;
    if (!ifb.CS) b_cslow <= b_cslow + 1;
    if (ifb.SCLK) b_high <= b_high + 1;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // {busy, CS, SCLK, SDI, done, aborted}
  function automatic logic [5:0] pins(input bit sel);
    if (sel)
      return {ifb.busy, ifb.CS, ifb.SCLK, ifb.SDI, ifb.done, ifb.aborted};
    return {ifa.busy, ifa.CS, ifa.SCLK, ifa.SDI, ifa.done, ifa.aborted};
  endfunction

  function automatic int rises_of(input bit sel);
    return sel ? b_rises : a_rises;
  endfunction

  task automatic drv(input bit sel, input logic s, input logic a);
    if (sel) begin
      ifb.start = s;
      ifb.abort = a;
    end else begin
      ifa.start = s;
      ifa.abort = a;
    end
  endtask

  int          r_n, r_nabt, r_rises, r_cslow, r_high;
  logic        r_ab;
  logic [63:0] r_cap;

  // caller sits at posedge+#1; r_n = cycle index of done after start edge
  task automatic frame(input bit sel, input logic [63:0] word,
                       input int poke_at, input int abt_rise,
                       input int rst_rise);
    int   n;
    bit   abt_on;
    int   b_r, b_c, b_h;
    logic [5:0] p;
    logic [63:0] ones;
    ones   = '1;
    r_n    = -1;
    r_nabt = -1;
    r_ab   = 1'b0;
    if (sel) ifb.cfg_word = word;
    else     ifa.cfg_word = word;
    if (sel) ifb.start = 1'b1;
    else     ifa.start = 1'b1;
    @(posedge clk);
    #1;
    drv(0, 0, 0);
    drv(1, 0, 0);
    chk("accept", {58'd0, pins(sel)}, {58'd0, 3'b100, word[63], 2'b00});
    b_r = rises_of(sel);
    b_c = sel ? b_cslow : a_cslow;
    b_h = sel ? b_high  : a_high;
    n = 0;
    abt_on = 0;
    while (n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (abt_on) begin
        drv(sel, 0, 0);
        abt_on = 0;
        r_nabt = n;
        chk("abort_pins", {58'd0, pins(sel)}, 64'b110000);
      end
      if (n == poke_at) begin
        drv(sel, 1, 0);
        if (sel) ifb.cfg_word = ones;
        else     ifa.cfg_word = ones;
      end
      if (n == poke_at + 1) drv(sel, 0, 0);
      if (rst_rise >= 0 && rises_of(sel) - b_r == rst_rise) begin
        rst_n = 1'b0;
        #1;
        chk("rst_pins", {58'd0, pins(sel)}, 64'b010000);
        r_n = -2;
        return;
      end
      p = pins(sel);
      if (abt_rise >= 0 && r_nabt < 0 && !abt_on &&
          rises_of(sel) - b_r == abt_rise && !p[3]) begin
        drv(sel, 0, 1);
        abt_on = 1;
      end
      if (p[1]) begin
        r_n  = n;
        r_ab = p[0];
        chk("done_pins", {60'd0, p[5:2]}, 64'b0100);
        break;
      end
    end
    if (r_n == -1) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done within %0d cycles", n);
    end
    r_rises = rises_of(sel) - b_r;
    r_cslow = (sel ? b_cslow : a_cslow) - b_c;
    r_high  = (sel ? b_high  : a_high)  - b_h;
    r_cap   = sel ? b_cap : a_cap;
  endtask

  typedef struct {
    logic [63:0] word;
    logic [63:0] exp_cap;
    int          exp_done;
    int          exp_rises;
    int          exp_cslow;
    int          exp_high;
  } vec_t;

  vec_t tv[4];

  initial begin
    // done cycle index 268: its cycle closes 269 clocks after the start edge
    tv[0] = '{64'h02DEECED5990D0D5, 64'h02DEECED5990D0D5, 268, 64, 264, 128};
    tv[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 268, 64, 264, 128};
    tv[2] = '{64'h0000000000000000, 64'h0000000000000000, 268, 64, 264, 128};
    tv[3] = '{64'hA5C3_0F1E_7788_9966, 64'hA5C3_0F1E_7788_9966, 268, 64, 264, 128};

    rst_n = 1'b0;
    ifa.start = 0; ifa.abort = 0; ifa.cfg_word = '0;
    ifb.start = 0; ifb.abort = 0; ifb.cfg_word = '0;

    // reset held with random start/abort
    repeat (8) begin
      @(posedge clk);
      #1;
      drv(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drv(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ifa.cfg_word = {$urandom, $urandom};
    end
    chk("rst_a", {58'd0, pins(0)}, 64'b010000);
    chk("rst_b", {58'd0, pins(1)}, 64'b010000);
    @(posedge clk);
    #1;
    drv(0, 0, 0);
    drv(1, 0, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_a", {58'd0, pins(0)}, 64'b010000);
    chk("post_rst_b", {58'd0, pins(1)}, 64'b010000);

    // nominal frames
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      frame(0, tv[i].word, -1, -1, -1);
      chk("tv_done",  64'(r_n),     64'(tv[i].exp_done));
      chk("tv_rises", 64'(r_rises), 64'(tv[i].exp_rises));
      chk("tv_cap",   r_cap,        tv[i].exp_cap);
      chk("tv_cslow", 64'(r_cslow), 64'(tv[i].exp_cslow));
      chk("tv_high",  64'(r_high),  64'(tv[i].exp_high));
      chk("tv_ab",    64'(r_ab),    64'd0);
    end

    // start/cfg_word poke while busy, then start in the done cycle
    @(posedge clk);
    #1;
    frame(0, 64'h02DEECED5990D0D5, 100, -1, -1);
    chk("poke_cap",  r_cap,    64'h02DEECED5990D0D5);
    chk("poke_done", 64'(r_n), 64'd268);
    frame(0, 64'h0123456789ABCDEF, -1, -1, -1);
    chk("b2b_cap",  r_cap,    64'h0123456789ABCDEF);
    chk("b2b_done", 64'(r_n), 64'd268);

    // abort in low phase of bit 10
    @(posedge clk);
    #1;
    frame(0, 64'h02DEECED5990D0D5, -1, 10, -1);
    chk("abt_rises", 64'(r_rises), 64'd10);
    chk("abt_flag",  64'(r_ab),    64'd1);
    chk("abt_gap",   64'(r_n - r_nabt), 64'd4);
    @(posedge clk);
    #1;
    chk("abt_after", {58'd0, pins(0)}, 64'b010000);

    // abort in IDLE is ignored
    drv(0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_abort", {58'd0, pins(0)}, 64'b010000);

    // abort together with start in IDLE: start wins
    frame(0, 64'h5A5A00FF1234C3C3, -1, -1, -1);
    chk("sa_cap", r_cap,       64'h5A5A00FF1234C3C3);
    chk("sa_ab",  64'(r_ab),   64'd0);
    chk("sa_done", 64'(r_n),   64'd268);

    // reset mid-frame around bit 30
    @(posedge clk);
    #1;
    frame(0, 64'hDEADBEEFCAFEF00D, -1, -1, 30);
    chk("rst_mid", 64'(r_n), -64'sd2);
    begin
      int dn;
      dn = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (ifa.done || ifa.busy) dn++;
      end
      chk("rst_no_done", 64'(dn), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame(0, 64'h02DEECED5990D0D5, -1, -1, -1);
    chk("rst_re_cap",  r_cap,    64'h02DEECED5990D0D5);
    chk("rst_re_done", 64'(r_n), 64'd268);

    // corner instance: 1-cycle everything
    @(posedge clk);
    #1;
    frame(1, 64'h8000000000000001, -1, -1, -1);
    chk("cor_done",  64'(r_n),     64'd131);
    chk("cor_rises", 64'(r_rises), 64'd64);
    chk("cor_cap",   r_cap,        64'h8000000000000001);
    chk("cor_high",  64'(r_high),  64'd64);
    chk("cor_cslow", 64'(r_cslow), 64'd130);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dogx_cfg_loader.md
Name: dogx_cfg_loader

Overview:
Serial configuration master that programs the DOGX `programmer` block. It takes a 64-bit configuration word through a start/busy/done handshake and drives the programmer's CS, SCLK and SDI pins. Each frame is sent MSB-first with programmable CS lead, lag and idle gaps. It sits between the host/control logic and the DOGX serial configuration interface, and is the only driver of those pins.

Parameters:
DATA_WIDTH, 64, frame length in bits (the programmer expects 64).
CLK_DIV, 8, clk cycles per SCLK half-period (≥1).
CS_LEAD, 2, clk cycles from CS falling to the start of bit 0's low phase (≥1).
CS_LAG, 2, clk cycles from the last SCLK falling edge to CS rising (≥1).
CS_IDLE, 4, clk cycles CS is held high after a frame before done (≥1).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous active-low reset.
start  input  1  request a frame; sampled only in IDLE.
cfg_word  input  DATA_WIDTH  configuration word; bit DATA_WIDTH-1 is sent first.
abort  input  1  synchronous frame abort.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse at frame end.
aborted  output  1  one-cycle pulse coincident with done when the frame was aborted.
CS  output  1  chip select to the programmer, active low.
SCLK  output  1  serial clock to the programmer; idles low; the programmer samples on the rising edge.
SDI  output  1  serial data to the programmer.

Behaviour:
- Reset (asynchronous, reset=0) forces these values: CS=1, SCLK=0, SDI=0, busy=0, done=0, aborted=0, state=IDLE, shift register=0, counters=0. Reset mid-frame takes effect immediately; there is no completion and no done.
- All outputs are registered with no glitches, and SCLK is a registered output, not a gated clock.
- FSM states and transitions:
  - IDLE -> LEAD -> SHIFT -> LAG -> GAP -> IDLE.
- IDLE:
  - start=1 latches cfg_word into the shift register.
  - On the next cycle: busy=1, CS=0, SDI=cfg_word[DATA_WIDTH-1], state=LEAD.
  - The done cycle counts as IDLE, so a start there is accepted back-to-back.
- LEAD: CS_LEAD cycles with SCLK=0.
- SHIFT: per bit, CLK_DIV cycles SCLK=0, then CLK_DIV cycles SCLK=1.
  - SDI advances to the next bit on the cycle SCLK falls (start of the next low phase). Each bit is therefore stable CLK_DIV cycles before and after its rising edge.
  - Exactly DATA_WIDTH rising edges occur per complete frame.
  - After the last high phase, SCLK=0 and state=LAG.
- LAG: CS_LAG cycles with CS=0 and SDI holding the last bit; then CS=1, SDI=0, state=GAP.
- GAP: CS_IDLE cycles; then done=1 and busy=0 in the same cycle, state=IDLE.
- Timing: done fires exactly 1+CS_LEAD+2·CLK_DIV·DATA_WIDTH+CS_LAG+CS_IDLE cycles after the start-sampling edge.
- Inputs while busy:
  - start while busy=1 is ignored, not queued.
  - cfg_word changes while busy have no effect on the frame in flight.
- abort=1 in LEAD, SHIFT or LAG:
  - Next cycle: SCLK=0, CS=1, SDI=0, state=GAP.
  - After CS_IDLE cycles, done=1 and aborted=1 together.
  - abort in IDLE or GAP is ignored.
  - abort and start in the same IDLE cycle: start wins.
- Counters: bit counter is ceil(log2(DATA_WIDTH+1)) bits; cycle counter is wide enough for max(CLK_DIV, CS_LEAD, CS_LAG, CS_IDLE). No wrap-around is permitted within a frame.

Test Plan:
1. Reset: hold reset=0 with random start and abort → CS=1, SCLK=0, SDI=0, busy=0, done=0; release reset → outputs unchanged until start.
2. Nominal frame:
   - Setup: DATA_WIDTH=64, CLK_DIV=2, CS_LEAD=4, CS_LAG=4, CS_IDLE=4; cfg_word=0x02DEECED5990D0D5, one start pulse.
   - Required: exactly 64 SCLK rises; bits captured at the rises equal 0x02DEECED5990D0D5.
   - Required: done exactly 269 cycles after the start edge; CS low for 264 cycles.
   - Required: the attached `programmer` outputs match the values decoded from the same word.
3. Handshake: pulse start at cycle 100 of a frame and change cfg_word to 0xFFFF… → no effect, captured word still 0x02DEECED5990D0D5. Then start in the done cycle → second frame begins on the next cycle with no idle gap beyond CS_IDLE.
4. Abort: assert abort during the low phase of bit 10 → next cycle CS=1, SCLK=0; only 10 rises seen; done and aborted pulse together 4 cycles later; busy=0.
5. Reset mid-frame: assert reset during bit 30 → CS=1, SCLK=0 immediately; no done. A new frame after release transmits correctly.
6. Corner: CLK_DIV=1, CS_LEAD=CS_LAG=CS_IDLE=1, word 0x8000000000000001 → SCLK toggles every cycle; SDI=1 at rises 1 and 64 only; done 132 cycles after start.
